// File: rtl/reg_write_stage_pkg.sv
// Shared types for the register write stage and the decode stage.
//   RWS_REG_COUNT : architectural registers per file
//   RWS_REG_AW    : register index width
//   reg_addr_t    : register index type
//   trap_cause_e  : trap cause encoding carried from decode to retirement
package reg_write_stage_pkg;

    localparam int RWS_REG_COUNT = 32;
    localparam int RWS_REG_AW    = $clog2(RWS_REG_COUNT);

    typedef logic [RWS_REG_AW-1:0] reg_addr_t;

    typedef enum logic [4:0] {
        TRAP_INSN_MISALIGNED  = 5'd0,
        TRAP_INSN_FAULT       = 5'd1,
        TRAP_ILLEGAL_INSN     = 5'd2,
        TRAP_BREAKPOINT       = 5'd3,
        TRAP_LOAD_MISALIGNED  = 5'd4,
        TRAP_LOAD_FAULT       = 5'd5,
        TRAP_STORE_MISALIGNED = 5'd6,
        TRAP_STORE_FAULT      = 5'd7,
        TRAP_ECALL_U          = 5'd8,
        TRAP_ECALL_S          = 5'd9,
        TRAP_ECALL_M          = 5'd11
    } trap_cause_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard for one register file.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : clear every busy bit; a set on the same cycle is dropped
//   set_en / set_addr  : a newly issued producer marks its destination busy
//   clr_en / clr_addr  : the retiring producer releases its destination
//   busy               : registered busy vector
// A set and a clear of the same register on the same cycle leaves it busy:
// the set belongs to a younger producer that has not retired yet.
module reg_scoreboard #(
    parameter  int REG_COUNT = 32,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic                 clr_en,
    input  logic [AW-1:0]        clr_addr,
    output logic [REG_COUNT-1:0] busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_write_stage.sv
// Final pipeline stage: retires the op coming from the memory stage, drives the
// int and fp register file write ports, tracks busy registers for the read
// stage, counts retired instructions and reports traps.
//
// Ports
//   clk, rst                        : clock, synchronous active-high reset
//   flush                           : pipeline flush (retiring op still commits)
//   in_valid, in_rd, in_int_wr, in_fp_wr, in_int_value, in_fp_value,
//   in_trap_valid, in_trap_cause    : retiring op
//   set_valid, set_rd, set_fp       : register read issuing a producer
//   q_rs1, q_rs2, q_rs3, q_rs3_fp, q_rs12_fp : hazard query
//   hazard                          : some queried source is still busy
//   int_we, int_waddr, int_wdata    : int register file write port (combinational)
//   fp_we, fp_waddr, fp_wdata       : fp register file write port (combinational)
//   int_busy, fp_busy               : scoreboard vectors
//   trap_valid, trap_cause          : one-cycle trap pulse, cause held until next trap
//   instret                         : retired-instruction counter (wraps)
//
// Build option RAFI_WB_BYPASS_EN adds byp_valid, byp_fp, byp_rd, byp_data: the
// previous cycle's committed write. A query that matches the bypass entry in
// the same file does not raise a hazard.
module reg_write_stage
    import reg_write_stage_pkg::*;
#(
    parameter  int XLEN          = 32,
    parameter  int FLEN          = 64,
    parameter  int REG_COUNT     = RWS_REG_COUNT,
    parameter  int INSTRET_WIDTH = 64,
    localparam int AW            = $clog2(REG_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [AW-1:0]            in_rd,
    input  logic                     in_int_wr,
    input  logic                     in_fp_wr,
    input  logic [XLEN-1:0]          in_int_value,
    input  logic [FLEN-1:0]          in_fp_value,
    input  logic                     in_trap_valid,
    input  logic [4:0]               in_trap_cause,
    input  logic                     set_valid,
    input  logic [AW-1:0]            set_rd,
    input  logic                     set_fp,
    input  logic [AW-1:0]            q_rs1,
    input  logic [AW-1:0]            q_rs2,
    input  logic [AW-1:0]            q_rs3,
    input  logic                     q_rs3_fp,
    input  logic                     q_rs12_fp,
    output logic                     hazard,
    output logic                     int_we,
    output logic [AW-1:0]            int_waddr,
    output logic [XLEN-1:0]          int_wdata,
    output logic                     fp_we,
    output logic [AW-1:0]            fp_waddr,
    output logic [FLEN-1:0]          fp_wdata,
    output logic [REG_COUNT-1:0]     int_busy,
    output logic [REG_COUNT-1:0]     fp_busy,
    output logic                     trap_valid,
    output logic [4:0]               trap_cause,
    output logic [INSTRET_WIDTH-1:0] instret
`ifdef RAFI_WB_BYPASS_EN
    ,
    output logic                     byp_valid,
    output logic                     byp_fp,
    output logic [AW-1:0]            byp_rd,
    output logic [FLEN-1:0]          byp_data
`endif
);

    logic                     commit;
    logic                     int_clr;
    logic                     fp_clr;
    logic                     int_set;
    logic                     fp_set;
    logic                     h_rs1;
    logic                     h_rs2;
    logic                     h_rs3;
    logic [INSTRET_WIDTH-1:0] instret_q;
    logic                     trap_valid_q;
    trap_cause_e              trap_cause_q;

    // rst gates the write ports so nothing is captured on a reset edge.
    assign commit    = in_valid & ~in_trap_valid & ~rst;
    assign int_we    = commit & in_int_wr & (in_rd != '0);
    // Both write flags together is illegal; the int write takes priority.
    assign fp_we     = commit & in_fp_wr & ~in_int_wr;
    assign int_waddr = in_rd;
    assign int_wdata = in_int_value;
    assign fp_waddr  = in_rd;
    assign fp_wdata  = in_fp_value;

    // A trapping op releases its destination too, otherwise the bit would leak.
    assign int_clr = in_valid & in_int_wr;
    assign fp_clr  = in_valid & in_fp_wr & ~in_int_wr;
    // x0 is hardwired, so it is never marked busy; f0 is a real register.
    assign int_set = set_valid & ~set_fp & (set_rd != '0);
    assign fp_set  = set_valid & set_fp;

    reg_scoreboard #(.REG_COUNT(REG_COUNT)) u_int_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (int_set),
        .set_addr (set_rd),
        .clr_en   (int_clr),
        .clr_addr (in_rd),
        .busy     (int_busy)
    );

    reg_scoreboard #(.REG_COUNT(REG_COUNT)) u_fp_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (fp_set),
        .set_addr (set_rd),
        .clr_en   (fp_clr),
        .clr_addr (in_rd),
        .busy     (fp_busy)
    );

    always_comb begin
        h_rs1 = q_rs12_fp ? fp_busy[q_rs1] : int_busy[q_rs1];
        h_rs2 = q_rs12_fp ? fp_busy[q_rs2] : int_busy[q_rs2];
        h_rs3 = q_rs3_fp & fp_busy[q_rs3];
`ifdef RAFI_WB_BYPASS_EN
        if (byp_valid && (byp_fp == q_rs12_fp) && (byp_rd == q_rs1)) h_rs1 = 1'b0;
        if (byp_valid && (byp_fp == q_rs12_fp) && (byp_rd == q_rs2)) h_rs2 = 1'b0;
        if (byp_valid && byp_fp && (byp_rd == q_rs3))                h_rs3 = 1'b0;
`endif
        hazard = h_rs1 | h_rs2 | h_rs3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q    <= '0;
            trap_valid_q <= 1'b0;
            trap_cause_q <= TRAP_INSN_MISALIGNED;
        end else begin
            if (commit) instret_q <= instret_q + INSTRET_WIDTH'(1);
            trap_valid_q <= in_valid & in_trap_valid;
            if (in_valid && in_trap_valid) trap_cause_q <= trap_cause_e'(in_trap_cause);
        end
    end

    assign instret    = instret_q;
    assign trap_valid = trap_valid_q;
    assign trap_cause = trap_cause_q;

`ifdef RAFI_WB_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            byp_valid <= 1'b0;
            byp_fp    <= 1'b0;
            byp_rd    <= '0;
            byp_data  <= '0;
        end else begin
            byp_valid <= int_we | fp_we;
            if (int_we) begin
                byp_fp   <= 1'b0;
                byp_rd   <= in_rd;
                byp_data <= FLEN'(in_int_value);
            end else if (fp_we) begin
                byp_fp   <= 1'b1;
                byp_rd   <= in_rd;
                byp_data <= in_fp_value;
            end
        end
    end
`endif

    a_one_write_file : assert property (@(posedge clk) disable iff (rst)
        !(in_valid && in_int_wr && in_fp_wr));

endmodule
